// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN constants, sequencer state encoding and saturating-add helper
package cnn_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int FC_OUTPUT_SIZE = 10;
    localparam logic [15:0] LOSS_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE,
        WAIT_LOW
    } state_t;

    // Unsigned add that clamps at the all-ones value of a width-bit result.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int width);
        logic [64:0] sum;
        logic [63:0] limit;
        limit = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        sum   = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, limit}) ? limit : sum[63:0];
    endfunction

endpackage

// File: rtl/fc_classifier_head.sv
// rtl/fc_classifier_head.sv - serial argmax / loss / accuracy head behind the FC layer
module fc_classifier_head #(
    parameter int FC_OUTPUT_SIZE = 10,
    parameter int DATA_WIDTH     = 16,
    parameter int CLASS_BITS     = 4,
    parameter int ACC_WIDTH      = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [FC_OUTPUT_SIZE*DATA_WIDTH-1:0] fc_data,
    input  logic [FC_OUTPUT_SIZE-1:0]            label,
    input  logic                                 clear_stats,
    output logic                                 done,
    output logic [CLASS_BITS-1:0]                predicted_class,
    output logic [CLASS_BITS-1:0]                true_class,
    output logic                                 correct,
    output logic [ACC_WIDTH-1:0]                 sample_loss,
    output logic [ACC_WIDTH-1:0]                 batch_loss,
    output logic [CNT_WIDTH-1:0]                 correct_count,
    output logic [CNT_WIDTH-1:0]                 sample_count
);
    import cnn_pkg::*;

    localparam int IDX_W = (FC_OUTPUT_SIZE > 1) ? $clog2(FC_OUTPUT_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FC_OUTPUT_SIZE - 1);

    state_t state, state_next;

    logic [DATA_WIDTH-1:0]     fc_mem [FC_OUTPUT_SIZE];
    logic [FC_OUTPUT_SIZE-1:0] label_reg;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          max_idx;
    logic [DATA_WIDTH-1:0]     max_val;
    logic [CLASS_BITS-1:0]     true_scan;
    logic                      true_found;
    logic [ACC_WIDTH-1:0]      loss_acc;

    logic [DATA_WIDTH-1:0]     elem;
    logic [ACC_WIDTH-1:0]      loss_term;
    logic                      sample_correct;
    logic [ACC_WIDTH-1:0]      batch_base, batch_sum;
    logic [CNT_WIDTH-1:0]      cnt_base, cnt_sum;
    logic [CNT_WIDTH-1:0]      corr_base, corr_sum;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (enable) state_next = SCAN;
            SCAN:     if (idx == LAST_IDX) state_next = DONE;
            DONE:     state_next = WAIT_LOW;
            WAIT_LOW: if (!enable) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // A clear coinciding with DONE restarts the statistics from this sample alone.
    always_comb begin
        elem           = fc_mem[idx];
        loss_term      = ACC_WIDTH'(LOSS_MAX - elem);
        sample_correct = true_found && (CLASS_BITS'(max_idx) == true_scan);
        batch_base     = clear_stats ? '0 : batch_loss;
        cnt_base       = clear_stats ? '0 : sample_count;
        corr_base      = clear_stats ? '0 : correct_count;
        batch_sum      = ACC_WIDTH'(sat_add(64'(batch_base), 64'(loss_acc), ACC_WIDTH));
        cnt_sum        = CNT_WIDTH'(sat_add(64'(cnt_base), 64'd1, CNT_WIDTH));
        corr_sum       = CNT_WIDTH'(sat_add(64'(corr_base), {63'd0, sample_correct}, CNT_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FC_OUTPUT_SIZE; i++) fc_mem[i] <= '0;
            label_reg       <= '0;
            idx             <= '0;
            max_idx         <= '0;
            max_val         <= '0;
            true_scan       <= '0;
            true_found      <= 1'b0;
            loss_acc        <= '0;
            done            <= 1'b0;
            predicted_class <= '0;
            true_class      <= '0;
            correct         <= 1'b0;
            sample_loss     <= '0;
            batch_loss      <= '0;
            correct_count   <= '0;
            sample_count    <= '0;
        end else begin
            done <= 1'b0;
            if (clear_stats && state != DONE) begin
                batch_loss    <= '0;
                correct_count <= '0;
                sample_count  <= '0;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        for (int i = 0; i < FC_OUTPUT_SIZE; i++)
                            fc_mem[i] <= fc_data[i*DATA_WIDTH +: DATA_WIDTH];
                        label_reg  <= label;
                        idx        <= '0;
                        max_idx    <= '0;
                        max_val    <= fc_data[DATA_WIDTH-1:0];
                        true_scan  <= '1;
                        true_found <= 1'b0;
                        loss_acc   <= '0;
                    end
                end
                SCAN: begin
                    if (elem > max_val) begin
                        max_val <= elem;
                        max_idx <= idx;
                    end
                    if (label_reg[idx]) begin
                        loss_acc <= loss_acc + loss_term;
                        if (!true_found) begin
                            true_scan  <= CLASS_BITS'(idx);
                            true_found <= 1'b1;
                        end
                    end
                    idx <= idx + 1'b1;
                end
                DONE: begin
                    done            <= 1'b1;
                    predicted_class <= CLASS_BITS'(max_idx);
                    true_class      <= true_scan;
                    correct         <= sample_correct;
                    sample_loss     <= loss_acc;
                    batch_loss      <= batch_sum;
                    correct_count   <= corr_sum;
                    sample_count    <= cnt_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_classifier_head.sv
// tb/tb_fc_classifier_head.sv - directed and randomized checks of fc_classifier_head against a behavioural model
module tb_fc_classifier_head;

    logic         clk = 1'b0;
    logic         reset, enable, clear_stats;
    logic [159:0] fc_data;
    logic [9:0]   label;

    logic         done, correct;
    logic [3:0]   predicted_class, true_class;
    logic [31:0]  sample_loss, batch_loss;
    logic [15:0]  correct_count, sample_count;

    logic         s_done, s_correct;
    logic [3:0]   s_predicted_class, s_true_class;
    logic [19:0]  s_sample_loss, s_batch_loss;
    logic [15:0]  s_correct_count, s_sample_count;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] vals [10];
    logic [9:0]  lab;
    int          e_pred, e_true;
    bit          e_corr;
    longint      e_loss;
    longint      m_batch, m_batch_s, m_cnt, m_corr;

    always #5 clk = ~clk;

    fc_classifier_head #(.FC_OUTPUT_SIZE(10), .DATA_WIDTH(16), .CLASS_BITS(4),
                         .ACC_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fc_data(fc_data), .label(label),
        .clear_stats(clear_stats), .done(done), .predicted_class(predicted_class),
        .true_class(true_class), .correct(correct), .sample_loss(sample_loss),
        .batch_loss(batch_loss), .correct_count(correct_count), .sample_count(sample_count)
    );

    // Narrow accumulator copy so batch-loss saturation is reachable in a short run.
    fc_classifier_head #(.FC_OUTPUT_SIZE(10), .DATA_WIDTH(16), .CLASS_BITS(4),
                         .ACC_WIDTH(20), .CNT_WIDTH(16)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .fc_data(fc_data), .label(label),
        .clear_stats(clear_stats), .done(s_done), .predicted_class(s_predicted_class),
        .true_class(s_true_class), .correct(s_correct), .sample_loss(s_sample_loss),
        .batch_loss(s_batch_loss), .correct_count(s_correct_count), .sample_count(s_sample_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic void model_sample();
        logic [15:0] best;
        best   = vals[0];
        e_pred = 0;
        for (int i = 1; i < 10; i++)
            if (vals[i] > best) begin best = vals[i]; e_pred = i; end
        e_true = 15;
        for (int i = 9; i >= 0; i--) if (lab[i]) e_true = i;
        e_corr = (lab != 0) && (e_pred == e_true);
        e_loss = 0;
        for (int i = 0; i < 10; i++) if (lab[i]) e_loss += 65535 - longint'(vals[i]);
    endfunction

    function automatic void model_clear();
        m_batch = 0; m_batch_s = 0; m_cnt = 0; m_corr = 0;
    endfunction

    function automatic void model_accum(input bit clr);
        if (clr) model_clear();
        m_cnt     = sat(m_cnt + 1, 65535);
        m_corr    = sat(m_corr + (e_corr ? 1 : 0), 65535);
        m_batch   = sat(m_batch + e_loss, 64'hFFFF_FFFF);
        m_batch_s = sat(m_batch_s + e_loss, 64'hF_FFFF);
    endfunction

    task automatic check_results();
        logic [61:0] s_obs, s_exp;
        check("predicted_class", predicted_class, e_pred);
        check("true_class", true_class, e_true);
        check("correct", correct, e_corr);
        check("sample_loss", sample_loss, e_loss);
        check("batch_loss", batch_loss, m_batch);
        check("correct_count", correct_count, m_corr);
        check("sample_count", sample_count, m_cnt);
        check("narrow_batch_loss", s_batch_loss, m_batch_s);
        s_obs = {s_done, s_predicted_class, s_true_class, s_correct, s_sample_loss,
                 s_correct_count, s_sample_count};
        s_exp = {1'b1, 4'(e_pred), 4'(e_true), e_corr, 20'(e_loss), 16'(m_corr), 16'(m_cnt)};
        check("narrow_instance", s_obs, s_exp);
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < 10; i++) fc_data[i*16 +: 16] = vals[i];
        label = lab;
    endtask

    // Entered and left at posedge+1 with enable low and the DUT idle.
    task automatic run_sample(input bit chk_lat, input bit clr_at_done);
        int cyc;
        bit seen;
        apply_inputs();
        enable = 1'b1;
        model_sample();
        model_accum(clr_at_done);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            clear_stats = clr_at_done && (cyc == 11);
            @(negedge clk);
            if (done) seen = 1;
        end
        clear_stats = 1'b0;
        check("done_seen", seen, 1);
        if (chk_lat) check("done_latency", cyc - 1, 11);
        check_results();
        @(posedge clk); #1;
        enable = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic clear_pulse();
        clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
        model_clear();
        @(negedge clk);
        check("clear_counts", {batch_loss, sample_count, correct_count}, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic rand_vals();
        for (int i = 0; i < 10; i++) vals[i] = 16'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, cyc;
        reset = 1'b1; enable = 1'b0; clear_stats = 1'b0; fc_data = '0; label = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_done", done, 0);
        check("reset_results", {predicted_class, true_class, correct, sample_loss}, 64'd0);
        check("reset_accums", {batch_loss, correct_count, sample_count}, 64'd0);
        @(posedge clk); #1;

        // Basic run: ramp with a single large element at the labelled class.
        for (int i = 0; i < 10; i++) vals[i] = 16'(i * 100);
        vals[7] = 16'h8000;
        lab = 10'b1 << 7;
        run_sample(1, 0);
        check("basic_pred_const", predicted_class, 7);
        check("basic_loss_const", sample_loss, 32'h7FFF);

        // Tie keeps the lowest index.
        for (int i = 0; i < 10; i++) vals[i] = 16'($urandom_range(16'h3FFF, 0));
        vals[2] = 16'h4000; vals[5] = 16'h4000;
        lab = 10'b1 << 5;
        run_sample(1, 0);
        check("tie_pred_const", predicted_class, 2);
        check("tie_loss_const", sample_loss, 32'hBFFF);

        // Empty label, then a two-hot label.
        clear_pulse();
        rand_vals();
        lab = '0;
        run_sample(0, 0);
        check("nolabel_true_const", true_class, 4'hF);
        check("nolabel_loss_const", sample_loss, 0);
        rand_vals();
        vals[0] = 16'h0001; vals[1] = 16'h0002;
        lab = 10'h003;
        run_sample(0, 0);
        check("twohot_true_const", true_class, 0);
        check("twohot_loss_const", sample_loss, 32'h1FFFB);
        check("twohot_count_const", sample_count, 2);

        // Randomized samples, mixing one-hot and arbitrary labels.
        for (int r = 0; r < 8; r++) begin
            rand_vals();
            if (r % 3 == 2) lab = 10'($urandom);
            else            lab = 10'b1 << $urandom_range(9, 0);
            if (r % 4 == 1) vals[$urandom_range(9, 0)] = 16'hFFFF;
            run_sample(1, 0);
        end

        // Enable held high: exactly one pulse, then a second after a low.
        clear_pulse();
        rand_vals();
        lab = 10'b1 << $urandom_range(9, 0);
        apply_inputs();
        enable = 1'b1;
        model_sample();
        model_accum(0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done) begin pulses++; check_results(); end
        end
        check("held_pulses", pulses, 1);
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rand_vals();
        lab = 10'b1 << $urandom_range(9, 0);
        run_sample(1, 0);
        check("held_count_const", sample_count, 2);

        // Clear landing in the DONE cycle after three prior samples.
        for (int r = 0; r < 3; r++) begin
            rand_vals();
            lab = 10'b1 << $urandom_range(9, 0);
            run_sample(0, 0);
        end
        rand_vals();
        lab = 10'($urandom) | 10'b1;
        run_sample(1, 1);
        check("clrdone_count_const", sample_count, 1);
        check("clrdone_batch_eq_loss", batch_loss, sample_loss);

        // Maximum-loss samples drive the narrow accumulator into saturation.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) vals[i] = 16'h0000;
            lab = 10'h3FF;
            run_sample(0, 0);
        end
        check("narrow_saturated_const", s_batch_loss, 20'hFFFFF);

        // Reset while scanning element 4.
        rand_vals();
        lab = 10'b1 << $urandom_range(9, 0);
        apply_inputs();
        enable = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 5) begin reset = 1'b1; enable = 1'b0; end
        end
        @(posedge clk);
        @(negedge clk);
        check("midscan_reset_done", done, 0);
        check("midscan_reset_results", {predicted_class, true_class, correct, sample_loss}, 64'd0);
        check("midscan_reset_accums", {batch_loss, correct_count, sample_count}, 64'd0);
        check("midscan_reset_narrow", {s_batch_loss, s_sample_count}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        pulses = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done) pulses++;
        end
        check("aborted_no_done", pulses, 0);
        @(posedge clk); #1;
        rand_vals();
        lab = 10'b1 << $urandom_range(9, 0);
        run_sample(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
